// File: rtl/stim_sequencer.sv
// stim_sequencer: plays a preloaded table of stimulus words over valid/ready,
// scores in-order responses against expected values and reports the results.
`default_nettype none

module stim_sequencer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int GAP_W  = 8,
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [DATA_W-1:0] load_data,
  input  logic [DATA_W-1:0] load_exp,
  input  logic [GAP_W-1:0]  load_gap,
  output logic              load_full,
  input  logic              clear,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
  output logic [7:0]        err_count,
  output logic [STEP_W-1:0] first_err_step,
  output logic [STEP_W-1:0] step
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_GAP   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic [PTR_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  play_ptr_q, play_ptr_d;
  logic [PTR_W-1:0]  rsp_ptr_q, rsp_ptr_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [7:0]        err_count_q, err_count_d;
  logic [STEP_W-1:0] first_err_q, first_err_d;
  logic [STEP_W-1:0] step_q, step_d;

  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [DATA_W-1:0] exp_mem_q  [DEPTH];
  logic [GAP_W-1:0]  gap_mem_q  [DEPTH];

  logic load_we;
  logic accept;
  logic mismatch;
  logic cmd_ok;
  logic busy_w;

  assign accept = out_valid_q && out_ready;
  assign busy_w = (state_q == S_DRIVE) || (state_q == S_GAP) || (state_q == S_DRAIN);
  assign cmd_ok = (state_q == S_IDLE) || (state_q == S_DONE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    play_ptr_d  = play_ptr_q;
    rsp_ptr_d   = rsp_ptr_q;
    gap_cnt_d   = gap_cnt_q;
    err_count_d = err_count_q;
    first_err_d = first_err_q;
    step_d      = step_q;
    load_we     = 1'b0;
    mismatch    = 1'b0;

    if (busy_w) step_d = step_q + 1'b1;

    // Responses past the end of the table are scored as errors without advancing.
    if (state_q != S_IDLE && rsp_valid) begin
      if (rsp_ptr_q == cnt_q) begin
        mismatch = 1'b1;
      end else begin
        mismatch  = (rsp_data != exp_mem_q[rsp_ptr_q[IDX_W-1:0]]);
        rsp_ptr_d = rsp_ptr_q + 1'b1;
      end
      if (mismatch) begin
        if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        if (err_count_q == 8'd0)  first_err_d = step_q;
      end
    end

    case (state_q)
      S_DRIVE: begin
        if (accept) begin
          play_ptr_d = play_ptr_q + 1'b1;
          if (gap_mem_q[play_ptr_q[IDX_W-1:0]] != '0) begin
            state_d   = S_GAP;
            gap_cnt_d = gap_mem_q[play_ptr_q[IDX_W-1:0]];
          end else if (play_ptr_d < cnt_q) begin
            state_d = S_DRIVE;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q <= GAP_W'(1)) begin
          state_d = (play_ptr_q < cnt_q) ? S_DRIVE : S_DRAIN;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      S_DRAIN: begin
        if (rsp_ptr_q == cnt_q) state_d = S_DONE;
      end
      default: ;
    endcase

    if (cmd_ok && clear) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      play_ptr_d  = '0;
      rsp_ptr_d   = '0;
      err_count_d = '0;
      first_err_d = '1;
      step_d      = '0;
    end else if (cmd_ok && start) begin
      state_d     = (cnt_q != '0) ? S_DRIVE : S_DONE;
      play_ptr_d  = '0;
      rsp_ptr_d   = '0;
      err_count_d = '0;
      first_err_d = '1;
      step_d      = '0;
    end else if (state_q == S_IDLE && load_en && cnt_q != PTR_W'(DEPTH)) begin
      load_we = 1'b1;
      cnt_d   = cnt_q + 1'b1;
    end

    // The play pointer only moves on acceptance, so the beat stays stable while stalled.
    out_valid_d = (state_d == S_DRIVE);
    out_data_d  = out_valid_d ? data_mem_q[play_ptr_d[IDX_W-1:0]] : out_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      play_ptr_q  <= '0;
      rsp_ptr_q   <= '0;
      gap_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_count_q <= '0;
      first_err_q <= '1;
      step_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      play_ptr_q  <= play_ptr_d;
      rsp_ptr_q   <= rsp_ptr_d;
      gap_cnt_q   <= gap_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_count_q <= err_count_d;
      first_err_q <= first_err_d;
      step_q      <= step_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_we) begin
      data_mem_q[cnt_q[IDX_W-1:0]] <= load_data;
      exp_mem_q[cnt_q[IDX_W-1:0]]  <= load_exp;
      gap_mem_q[cnt_q[IDX_W-1:0]]  <= load_gap;
    end
  end

  assign load_full      = (cnt_q == PTR_W'(DEPTH));
  assign busy           = busy_w;
  assign done           = (state_q == S_DONE);
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign err_count      = err_count_q;
  assign first_err_step = first_err_q;
  assign step           = step_q;

endmodule

`default_nettype wire

// File: tb/tb_stim_sequencer.sv
// Directed self-checking bench for stim_sequencer with hand-computed expectations.
`default_nettype none

module tb_stim_sequencer;

  logic        clk;
  logic        rst_n;
  logic        load_en;
  logic [7:0]  load_data;
  logic [7:0]  load_exp;
  logic [7:0]  load_gap;
  logic        load_full;
  logic        clear;
  logic        start;
  logic        busy;
  logic        done;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic [7:0]  err_count;
  logic [15:0] first_err_step;
  logic [15:0] step;

  logic       echo_en;
  logic       man_valid;
  logic [7:0] man_data;

  int n_checks;
  int n_errors;
  int cyc;
  logic [7:0] beats[$];
  int         beat_cyc[$];

  // The modelled DUT echoes each accepted stimulus in the same cycle.
  assign rsp_valid = echo_en ? (out_valid && out_ready) : man_valid;
  assign rsp_data  = echo_en ? out_data : man_data;

  stim_sequencer #(.DATA_W(8), .DEPTH(16), .GAP_W(8), .STEP_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_en(load_en), .load_data(load_data), .load_exp(load_exp), .load_gap(load_gap),
    .load_full(load_full), .clear(clear), .start(start), .busy(busy), .done(done),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .err_count(err_count), .first_err_step(first_err_step), .step(step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (out_valid && out_ready) begin
      beats.push_back(out_data);
      beat_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] d, input logic [7:0] e, input logic [7:0] g);
    load_en = 1'b1; load_data = d; load_exp = e; load_gap = g;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", {31'd0, done}, 32'd1);
  endtask

  task automatic clr_beats();
    beats.delete();
    beat_cyc.delete();
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0;
    rst_n = 1'b0; load_en = 1'b0; load_data = '0; load_exp = '0; load_gap = '0;
    clear = 1'b0; start = 1'b0; out_ready = 1'b0;
    echo_en = 1'b1; man_valid = 1'b0; man_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {24'd0, err_count}, 32'd0);
    check("rst_first", {16'd0, first_err_step}, 32'h0000FFFF);
    check("rst_step", {16'd0, step}, 32'd0);
    check("rst_full", {31'd0, load_full}, 32'd0);

    // Three gap-0 beats with echoed responses
    load(8'h11, 8'h11, 8'd0);
    load(8'h22, 8'h22, 8'd0);
    load(8'h33, 8'h33, 8'd0);
    out_ready = 1'b1;
    clr_beats();
    pulse_start();
    wait_done(50);
    check("t1_nbeats", beats.size(), 32'd3);
    if (beats.size() == 3) begin
      check("t1_beat0", {24'd0, beats[0]}, 32'h11);
      check("t1_beat1", {24'd0, beats[1]}, 32'h22);
      check("t1_beat2", {24'd0, beats[2]}, 32'h33);
      check("t1_b2b", beat_cyc[2] - beat_cyc[0], 32'd2);
    end
    check("t1_err", {24'd0, err_count}, 32'd0);
    check("t1_first", {16'd0, first_err_step}, 32'h0000FFFF);
    check("t1_busy", {31'd0, busy}, 32'd0);

    // Second entry expects 0x23: one error, captured at step 1
    pulse_clear();
    check("clr_done", {31'd0, done}, 32'd0);
    load(8'h11, 8'h11, 8'd0);
    load(8'h22, 8'h23, 8'd0);
    load(8'h33, 8'h33, 8'd0);
    pulse_start();
    wait_done(50);
    check("t2_err", {24'd0, err_count}, 32'd1);
    check("t2_first", {16'd0, first_err_step}, 32'd1);

    // Gap of 3 after a stalled first beat
    pulse_clear();
    load(8'hA1, 8'hA1, 8'd3);
    load(8'hB2, 8'hB2, 8'd0);
    out_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      check("t3_stall_valid", {31'd0, out_valid}, 32'd1);
      check("t3_stall_data", {24'd0, out_data}, 32'hA1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    begin
      int idle = 0;
      while (!out_valid && idle < 20) begin
        idle++;
        @(negedge clk);
      end
      check("t3_idle_cycles", idle, 32'd3);
    end
    check("t3_second_data", {24'd0, out_data}, 32'hB2);
    wait_done(50);
    check("t3_err", {24'd0, err_count}, 32'd0);

    // DEPTH+1 loads: the 17th is dropped
    pulse_clear();
    for (int i = 0; i < 16; i++) load(8'h40 + 8'(i), 8'h40 + 8'(i), 8'd0);
    check("t4_full16", {31'd0, load_full}, 32'd1);
    load(8'h50, 8'h50, 8'd0);
    check("t4_full17", {31'd0, load_full}, 32'd1);
    clr_beats();
    pulse_start();
    wait_done(100);
    check("t4_nbeats", beats.size(), 32'd16);
    if (beats.size() == 16) check("t4_last", {24'd0, beats[15]}, 32'h4F);
    check("t4_err", {24'd0, err_count}, 32'd0);

    // Extra response after completion
    pulse_clear();
    load(8'h71, 8'h71, 8'd0);
    load(8'h72, 8'h72, 8'd0);
    pulse_start();
    wait_done(50);
    check("t5_err_before", {24'd0, err_count}, 32'd0);
    check("t5_step", {16'd0, step}, 32'd3);
    echo_en = 1'b0; man_valid = 1'b1; man_data = 8'h72;
    @(negedge clk);
    man_valid = 1'b0;
    @(negedge clk);
    check("t5_err_after", {24'd0, err_count}, 32'd1);
    check("t5_first", {16'd0, first_err_step}, 32'd3);
    check("t5_done", {31'd0, done}, 32'd1);
    echo_en = 1'b1;

    // Asynchronous reset during a gap, then reload and replay
    pulse_clear();
    load(8'h55, 8'h55, 8'd5);
    load(8'h56, 8'h56, 8'd5);
    pulse_start();
    @(negedge clk);
    check("t6_in_gap_valid", {31'd0, out_valid}, 32'd0);
    check("t6_in_gap_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_err", {24'd0, err_count}, 32'd0);
    check("t6_rst_full", {31'd0, load_full}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load(8'h61, 8'h61, 8'd0);
    load(8'h62, 8'h62, 8'd0);
    clr_beats();
    pulse_start();
    wait_done(50);
    check("t6_nbeats", beats.size(), 32'd2);
    if (beats.size() == 2) check("t6_first_beat", {24'd0, beats[0]}, 32'h61);
    check("t6_err", {24'd0, err_count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
